// File: rtl/mux_nx1_arbiter.sv
// Round-robin arbiter that owns the select line of a shared mux_nx1 datapath.
// One requester holds the grant until it signals done, drops its request, or
// reaches the hold limit; the next owner is chosen in the same cycle so the
// grant passes on without an idle bubble.
module mux_nx1_arbiter #(
  parameter  int SIZE     = 8,
  parameter  int MAX_HOLD = 16,
  localparam int SEL_W    = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIZE-1:0]  arb_req,
  input  logic             arb_done,
  output logic [SIZE-1:0]  arb_gnt,
  output logic [SEL_W-1:0] arb_sel,
  output logic             arb_busy,
  output logic             arb_timeout
);

  // A zero-width counter is illegal, so a disabled timeout still keeps one bit.
  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [SIZE-1:0]  gnt_n;
  logic [SEL_W-1:0] sel_n;
  logic             timeout_n;

  logic             owner_req;
  logic             limit_hit;
  logic             release_now;
  logic [SEL_W-1:0] next_ptr;
  logic [SEL_W-1:0] search_ptr;
  logic [SIZE-1:0]  masked_req;
  logic [SIZE-1:0]  search_req;
  logic [SEL_W:0]   search_res;
  logic             win_found;
  logic [SEL_W-1:0] win_idx;

  // Circular priority search starting at 'start'; returns {found, index}.
  // Indices are reduced modulo SIZE so a non-power-of-two SIZE never yields
  // an out-of-range select.
  function automatic logic [SEL_W:0] find_winner(input logic [SIZE-1:0]  req,
                                                 input logic [SEL_W-1:0] start);
    logic [SEL_W:0] res;
    int             idx;
    res = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= SIZE) idx = idx - SIZE;
      // Scanning from lowest priority to highest lets the last hit win.
      if (req[idx]) res = {1'b1, SEL_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [SIZE-1:0] onehot(input logic [SEL_W-1:0] idx);
    return {{(SIZE - 1){1'b0}}, 1'b1} << idx;
  endfunction

  // Release decision and same-cycle winner search for the next owner.
  always_comb begin
    owner_req   = arb_req[arb_sel];
    limit_hit   = (MAX_HOLD != 0) && (cnt == CNT_W'(MAX_HOLD - 1));
    release_now = (state == GRANT) && (arb_done || !owner_req || limit_hit);
    next_ptr    = (arb_sel == SEL_W'(SIZE - 1)) ? '0 : arb_sel + 1'b1;
    masked_req  = arb_req & ~onehot(arb_sel);
    // The releasing owner is skipped unless nobody else is asking.
    if (release_now && (masked_req != '0)) search_req = masked_req;
    else                                   search_req = arb_req;
    search_ptr  = release_now ? next_ptr : ptr;
    search_res  = find_winner(search_req, search_ptr);
    win_found   = search_res[SEL_W];
    win_idx     = search_res[SEL_W-1:0];
  end

  // Next-state and next-output logic for the IDLE/GRANT controller.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    gnt_n     = arb_gnt;
    sel_n     = arb_sel;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_n = GRANT;
          gnt_n   = onehot(win_idx);
          sel_n   = win_idx;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_n     = next_ptr;
          timeout_n = limit_hit && !arb_done && owner_req;
          if (win_found) begin
            gnt_n = onehot(win_idx);
            sel_n = win_idx;
            cnt_n = '0;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
          end
        end else if (cnt != {CNT_W{1'b1}}) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      arb_gnt     <= '0;
      arb_sel     <= '0;
      arb_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register see the pre-edge
      // values of the others, independent of statement order.
      state       <= state_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
      arb_gnt     <= gnt_n;
      arb_sel     <= sel_n;
      arb_timeout <= timeout_n;
    end
  end

  assign arb_busy = (state == GRANT);

endmodule

// File: doc/mux_nx1_arbiter.md
Name: mux_nx1_arbiter

Overview:
Round-robin arbiter that shares one mux_nx1 datapath among SIZE requesters. It grants exactly one requester at a time and drives the mux select with the winner's index. The grant holds until the owner signals done, drops its request, or reaches the hold timeout. It sits directly in front of mux_nx1; arb_sel connects to mux_nx1_sel.

Parameters:
SIZE, 8, number of requesters and mux inputs; must be >= 2.
SEL_W, $clog2(SIZE), select width; derived, not overridden.
MAX_HOLD, 16, maximum consecutive grant cycles per ownership; 0 disables the timeout.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
arb_req  input  SIZE  request vector; bit i high means requester i wants the mux.
arb_done  input  1  owner finished; one-cycle pulse, sampled only in GRANT.
arb_gnt  output  SIZE  one-hot grant, registered; all zeros when no owner.
arb_sel  output  SEL_W  index of the current or last owner; drives mux_nx1_sel.
arb_busy  output  1  high while in GRANT.
arb_timeout  output  1  one-cycle pulse on the cycle a timeout release is registered.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Outputs: arb_gnt=0, arb_sel=0, arb_busy=0, arb_timeout=0.
  - Internal: state=IDLE, priority pointer ptr=0, hold counter=0.
- All outputs are registered. There is no combinational path from arb_req or arb_done to any output.
- Winner search: the first asserted arb_req bit at index ptr, ptr+1, ..., SIZE-1, 0, ..., ptr-1 (circular). Requester ptr has highest priority.
- IDLE:
  - If arb_req!=0: on the next edge arb_gnt=onehot(winner), arb_sel=winner, arb_busy=1, hold counter=0, state=GRANT. Latency from request to grant is 1 cycle.
  - If arb_req==0: stay in IDLE. arb_sel keeps the last owner index so the mux output stays stable. arb_done is ignored.
- GRANT:
  - The hold counter increments each cycle.
  - Release condition: arb_done=1, or arb_req[owner]=0, or (MAX_HOLD!=0 and counter==MAX_HOLD-1).
  - Simultaneous causes produce one release only. arb_timeout pulses only if the counter limit was hit and neither arb_done nor the request drop occurred.
  - On release:
    - ptr = (owner+1) mod SIZE; owner SIZE-1 wraps to 0.
    - The winner search runs in the same cycle using the updated ptr and arb_req masked to exclude the releasing owner, unless that owner is the only requester.
    - If a winner exists: grant it on the next edge with no idle bubble. If the only requester is the releasing owner and its request is still high, it is regranted.
    - If no request: arb_gnt=0, arb_busy=0, state=IDLE.
  - Requests that arrive or change while an owner holds the grant do not preempt it.
- Width rules:
  - arb_sel is never >= SIZE, including for non-power-of-two SIZE.
  - ptr wraps modulo SIZE, not modulo 2^SEL_W.
  - The hold counter is $clog2(MAX_HOLD+1) bits wide and saturates; it never wraps.
- Invariants:
  - arb_gnt is either zero or one-hot.
  - arb_busy == (arb_gnt!=0).
  - arb_gnt[arb_sel]==1 whenever arb_busy is high.
- Reset mid-grant: arb_gnt clears asynchronously. After reset deasserts, arbitration restarts from ptr=0.

Test Plan:
1. arb_req=8'hFF held through reset release -> 1 clock after deassertion: arb_gnt=8'h01, arb_sel=0, arb_busy=1.
2. arb_req=8'hFF with an arb_done pulse 3 cycles into each grant -> grants 0,1,...,7,0 in order; arb_busy stays 1 with no gap cycles; arb_sel tracks the owner index.
3. Grant owner 4 and pulse arb_done so ptr=5, then arb_req=8'h90 -> grant 7 first; after arb_done, grant 4; arb_gnt never has two bits set.
4. MAX_HOLD=16, arb_req=8'h01 held, no arb_done -> arb_gnt=8'h01 for 16 cycles; arb_timeout pulses once; owner 0 regranted with no bubble. Repeat with arb_done on cycle 16 -> arb_timeout stays 0.
5. Async rst pulse mid-grant between clock edges -> arb_gnt=0 and arb_busy=0 immediately. After release with arb_req=8'h20 -> arb_gnt=8'h20 after 1 clock.
6. SIZE=5 instance, arb_req=5'h11, alternate done pulses -> sel sequence 0,4,0,4; arb_sel never exceeds 4; owner 4 releases to ptr=0. arb_req=0 -> IDLE with arb_sel holding 4.
